// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state type, the default operand width and the counter sizing helper.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/ready/valid handshake plus operand and result bundle for serial_subtractor.
interface serial_subtractor_if
  import sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;

  modport master (
    output start, a, b,
    input  ready, busy, valid, diff, borrow, ovf
  );

  modport slave (
    input  start, a, b,
    output ready, busy, valid, diff, borrow, ovf
  );

endinterface

// File: rtl/full_subtractor.sv
// Combinational one-bit full-subtractor cell: d = x - y - bin, bout is the borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, through one full-subtractor cell.
// Results are registered on the last shift and held until the next completed operation.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic fs_d;
  logic fs_bout;

  full_subtractor u_fs (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .bin  (br_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // NOTE: every variable is given its hold value first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          br_d    = 1'b0;
          cnt_d   = '0;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = {fs_d, res_q[WIDTH-1:1]};
        br_d   = fs_bout;
        cnt_d  = cnt_q + CW'(1);
        // Last shift: publish the result on the same edge that enters DONE.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          diff_d   = {fs_d, res_q[WIDTH-1:1]};
          borrow_d = fs_bout;
          ovf_d    = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.busy   = (state_q == SHIFT);
  assign bus.valid  = (state_q == DONE);
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of serial_subtractor at WIDTH=4.
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Waits for ready, accepts one operation, then waits (bounded) for valid.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        output logic [3:0] diff, output logic borrow, output logic ovf,
                        output int lat, output logic [3:0] diff_at_accept,
                        output logic busy_at_accept);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    while (!bus.ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
    diff_at_accept = bus.diff;
    busy_at_accept = bus.busy;
    lat = 0;
    while (!bus.valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    diff   = bus.diff;
    borrow = bus.borrow;
    ovf    = bus.ovf;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.ready !== 1'b1)   begin errors++; $display("FAIL reset_ready got %b exp 1", bus.ready); end
    checks++; if (bus.busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b exp 0", bus.valid); end
    checks++; if (bus.diff !== 4'b0000) begin errors++; $display("FAIL reset_diff got %b exp 0000", bus.diff); end
    checks++; if (bus.borrow !== 1'b0)  begin errors++; $display("FAIL reset_borrow got %b exp 0", bus.borrow); end
    checks++; if (bus.ovf !== 1'b0)     begin errors++; $display("FAIL reset_ovf got %b exp 0", bus.ovf); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [3:0] d, d_acc;
    logic       br, ov, bsy;
    int         lat;
    run_op(4'b0001, 4'b0001, d, br, ov, lat, d_acc, bsy);
    checks++; if (bsy !== 1'b1)  begin errors++; $display("FAIL basic1_busy got %b exp 1", bsy); end
    checks++; if (lat != 4)      begin errors++; $display("FAIL basic1_latency got %0d exp 4", lat); end
    checks++; if (d !== 4'b0000) begin errors++; $display("FAIL basic1_diff got %b exp 0000", d); end
    checks++; if (br !== 1'b0)   begin errors++; $display("FAIL basic1_borrow got %b exp 0", br); end
    checks++; if (ov !== 1'b0)   begin errors++; $display("FAIL basic1_ovf got %b exp 0", ov); end
    @(posedge clk);
    #1;
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL basic1_valid_pulse got %b exp 0", bus.valid); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL basic1_ready_after got %b exp 1", bus.ready); end

    run_op(4'b0011, 4'b0101, d, br, ov, lat, d_acc, bsy);
    checks++; if (lat != 4)      begin errors++; $display("FAIL basic2_latency got %0d exp 4", lat); end
    checks++; if (d !== 4'b1110) begin errors++; $display("FAIL basic2_diff got %b exp 1110", d); end
    checks++; if (br !== 1'b1)   begin errors++; $display("FAIL basic2_borrow got %b exp 1", br); end
    checks++; if (ov !== 1'b0)   begin errors++; $display("FAIL basic2_ovf got %b exp 0", ov); end
  endtask

  task automatic test_overflow();
    logic [3:0] d, d_acc;
    logic       br, ov, bsy;
    int         lat;
    run_op(4'b1000, 4'b0001, d, br, ov, lat, d_acc, bsy);
    checks++; if (d !== 4'b0111) begin errors++; $display("FAIL ovf1_diff got %b exp 0111", d); end
    checks++; if (br !== 1'b0)   begin errors++; $display("FAIL ovf1_borrow got %b exp 0", br); end
    checks++; if (ov !== 1'b1)   begin errors++; $display("FAIL ovf1_ovf got %b exp 1", ov); end

    run_op(4'b0111, 4'b1111, d, br, ov, lat, d_acc, bsy);
    checks++; if (d_acc !== 4'b0111) begin errors++; $display("FAIL ovf2_diff_held got %b exp 0111", d_acc); end
    checks++; if (d !== 4'b1000) begin errors++; $display("FAIL ovf2_diff got %b exp 1000", d); end
    checks++; if (br !== 1'b1)   begin errors++; $display("FAIL ovf2_borrow got %b exp 1", br); end
    checks++; if (ov !== 1'b1)   begin errors++; $display("FAIL ovf2_ovf got %b exp 1", ov); end
  endtask

  // start held high: accepts at E0 and E6, valid at E4 and E10 only.
  task automatic test_back_to_back();
    int guard;
    int nvalid;
    guard  = 0;
    nvalid = 0;
    @(negedge clk);
    bus.a     = 4'b0101;
    bus.b     = 4'b0010;
    bus.start = 1'b1;
    while (!bus.ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus.a = 4'b0000;
    bus.b = 4'b0001;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      if (bus.valid) nvalid++;
      if (k == 4) begin
        checks++; if (bus.valid !== 1'b1)   begin errors++; $display("FAIL b2b1_valid got %b exp 1", bus.valid); end
        checks++; if (bus.diff !== 4'b0011) begin errors++; $display("FAIL b2b1_diff got %b exp 0011", bus.diff); end
        checks++; if (bus.borrow !== 1'b0)  begin errors++; $display("FAIL b2b1_borrow got %b exp 0", bus.borrow); end
        checks++; if (bus.ovf !== 1'b0)     begin errors++; $display("FAIL b2b1_ovf got %b exp 0", bus.ovf); end
      end
      if (k == 7) begin
        bus.a = 4'b1111;
        bus.b = 4'b1111;
      end
      if (k == 10) begin
        checks++; if (bus.valid !== 1'b1)   begin errors++; $display("FAIL b2b2_valid got %b exp 1", bus.valid); end
        checks++; if (bus.diff !== 4'b1111) begin errors++; $display("FAIL b2b2_diff got %b exp 1111", bus.diff); end
        checks++; if (bus.borrow !== 1'b1)  begin errors++; $display("FAIL b2b2_borrow got %b exp 1", bus.borrow); end
        checks++; if (bus.ovf !== 1'b0)     begin errors++; $display("FAIL b2b2_ovf got %b exp 0", bus.ovf); end
        bus.start = 1'b0;
      end
    end
    checks++; if (nvalid != 2) begin errors++; $display("FAIL b2b_valid_count got %0d exp 2", nvalid); end
  endtask

  task automatic test_reset_mid();
    int         guard;
    int         nvalid;
    logic [3:0] d, d_acc;
    logic       br, ov, bsy;
    int         lat;
    guard  = 0;
    nvalid = 0;
    @(negedge clk);
    bus.a     = 4'b1100;
    bus.b     = 4'b0001;
    bus.start = 1'b1;
    while (!bus.ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.ready !== 1'b1)   begin errors++; $display("FAIL rmid_ready got %b exp 1", bus.ready); end
    checks++; if (bus.busy !== 1'b0)    begin errors++; $display("FAIL rmid_busy got %b exp 0", bus.busy); end
    checks++; if (bus.valid !== 1'b0)   begin errors++; $display("FAIL rmid_valid got %b exp 0", bus.valid); end
    checks++; if (bus.diff !== 4'b0000) begin errors++; $display("FAIL rmid_diff got %b exp 0000", bus.diff); end
    checks++; if (bus.borrow !== 1'b0)  begin errors++; $display("FAIL rmid_borrow got %b exp 0", bus.borrow); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.valid) nvalid++;
    end
    checks++; if (nvalid != 0) begin errors++; $display("FAIL rmid_no_valid got %0d exp 0", nvalid); end

    run_op(4'b1010, 4'b0011, d, br, ov, lat, d_acc, bsy);
    checks++; if (lat != 4)      begin errors++; $display("FAIL rmid_op_latency got %0d exp 4", lat); end
    checks++; if (d !== 4'b0111) begin errors++; $display("FAIL rmid_op_diff got %b exp 0111", d); end
    checks++; if (br !== 1'b0)   begin errors++; $display("FAIL rmid_op_borrow got %b exp 0", br); end
    checks++; if (ov !== 1'b1)   begin errors++; $display("FAIL rmid_op_ovf got %b exp 1", ov); end
  endtask

  task automatic test_sweep();
    logic [3:0] d, d_acc, exp_d;
    logic       br, ov, bsy, exp_br, exp_ov;
    int         lat, sa, sb, sr;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        run_op(4'(ia), 4'(ib), d, br, ov, lat, d_acc, bsy);
        exp_d  = 4'((ia - ib + 16) % 16);
        exp_br = (ia < ib);
        sa     = (ia >= 8) ? ia - 16 : ia;
        sb     = (ib >= 8) ? ib - 16 : ib;
        sr     = sa - sb;
        exp_ov = (sr > 7) || (sr < -8);
        checks++; if (d !== exp_d)   begin errors++; $display("FAIL sweep_diff a=%0d b=%0d got %b exp %b", ia, ib, d, exp_d); end
        checks++; if (br !== exp_br) begin errors++; $display("FAIL sweep_borrow a=%0d b=%0d got %b exp %b", ia, ib, br, exp_br); end
        checks++; if (ov !== exp_ov) begin errors++; $display("FAIL sweep_ovf a=%0d b=%0d got %b exp %b", ia, ib, ov, exp_ov); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL timeout simulation exceeded 300000 time units");
    $fatal(1, "timeout");
  end

endmodule
